// File: rtl/fft_bitrev_out_if.sv
// Purpose: handshake bundle between the FFT core, the reorder buffer and the consumer.
// Ports: in_valid/in_sop/in_data/in_ready (core side), out_valid/out_ready/out_data/out_last (consumer side).
// Modports: slave = reorder buffer view, master = driver/consumer view.
interface fft_bitrev_out_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_sop;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_sop, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_sop, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_bitrev_out.sv
// Purpose: ping-pong reorder buffer; bit-reversed FFT results in, natural-order words out.
// Latency: first natural-order word valid the cycle after the 16th write; 1 word/cycle both sides.
// Backpressure: in_ready drops only when both banks are full; out_data/out_last hold while out_ready is low.
// Ports: clk, rst_n (async, active low); bus (slave modport: in/out handshakes);
//        sop_err (sticky early-restart flag); frame_cnt (frames fully drained, wraps).
module fft_bitrev_out #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_bitrev_out_if.slave     bus,
  output logic                sop_err,
  output logic [7:0]          frame_cnt
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  // Storage and control state
  logic [DATA_W-1:0] mem [2][N_POINTS];
  logic [1:0]        full;
  logic              wb;
  logic              rb;
  logic [LOG2N-1:0]  wcnt;
  logic [LOG2N-1:0]  rcnt;

  logic              in_ready_w;
  logic              out_valid_w;
  logic              wr_acc;
  logic              rd_acc;
  logic              resync;
  logic [LOG2N-1:0]  wr_addr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Ready/valid depend on registered flags only, so there is no combinational
  // path from in_valid or out_ready.
  assign in_ready_w  = ~full[wb];
  assign out_valid_w = full[rb];

  assign wr_acc = bus.in_valid & in_ready_w;
  assign rd_acc = out_valid_w & bus.out_ready;

  // An sop in the middle of a frame throws away the partial frame and
  // restarts it with this word as element 0 (bitrev(0) == 0).
  assign resync  = bus.in_sop & (wcnt != '0);
  assign wr_addr = resync ? '0 : bitrev(wcnt);

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = mem[rb][rcnt];
  assign bus.out_last  = out_valid_w & (rcnt == LAST_IDX);

  // Frame memory is deliberately not reset; full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wb][wr_addr] <= bus.in_data;
    end
  end

  // The writer only ever targets a non-full bank and the reader a full one,
  // so the set and clear of full[] below never hit the same bit in a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      frame_cnt <= '0;
      sop_err   <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (resync) begin
          wcnt    <= LOG2N'(1);
          sop_err <= 1'b1;
        end else if (wcnt == LAST_IDX) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wcnt     <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      if (rd_acc) begin
        if (rcnt == LAST_IDX) begin
          full[rb]  <= 1'b0;
          rb        <= ~rb;
          rcnt      <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_out.sv
module tb_fft_bitrev_out;

  logic       clk;
  logic       rst_n;
  logic       sop_err;
  logic [7:0] frame_cnt;

  fft_bitrev_out_if #(.DATA_W(32)) bus ();

  fft_bitrev_out #(.N_POINTS(16), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sop_err   (sop_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit last_acc = 0;

  logic [31:0] obs_dat [$];
  bit          obs_last[$];
  int          obs_cyc [$];

  // Natural index n holds input position rev_tbl[n] (hand-computed 4-bit mirror).
  int rev_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int v);
    return {v[15:0], ~v[15:0]};
  endfunction

  // One clock cycle: sample at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    last_acc = bus.in_valid && bus.in_ready;
    if (bus.in_valid && !bus.in_ready) stall_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      obs_dat.push_back(bus.out_data);
      obs_last.push_back(bus.out_last);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit sop, output int waits);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_data  = d;
    waits = 0;
    do begin
      cycle();
      waits++;
    end while (!last_acc && waits < 200);
    if (!last_acc) chk("write_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic send_frame(input int base);
    int w;
    for (int k = 0; k < 16; k++) send_word(wd(base + k), k == 0, w);
  endtask

  task automatic drain(input int n);
    int b;
    b = 0;
    bus.out_ready = 1'b1;
    while (obs_dat.size() < n && b < 1000) begin
      cycle();
      b++;
    end
    chk("drain_count", obs_dat.size(), n);
  endtask

  task automatic check_frame(input string tag, input int obs_base, input int val_base);
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("%s_dat%0d", tag, n), obs_dat[obs_base + n], wd(val_base + rev_tbl[n]));
      chk($sformatf("%s_last%0d", tag, n), obs_last[obs_base + n], n == 15);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_dat.delete();
    obs_last.delete();
    obs_cyc.delete();
    stall_cnt = 0;
  endtask

  initial begin
    int w;
    int c0;
    logic [31:0] held;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_sop_err", sop_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // ---------------- single frame ----------------
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send_word(wd(k), k == 0, w);
      if (k == 14) chk("t1_valid_before_16th", bus.out_valid, 0);
    end
    chk("t1_valid_after_16th", bus.out_valid, 1);
    chk("t1_first_word", bus.out_data, wd(0));
    drain(16);
    check_frame("t1", 0, 0);
    chk("t1_frame_cnt", frame_cnt, 1);

    // ---------------- 4 back-to-back frames ----------------
    do_reset();
    bus.out_ready = 1'b1;
    c0 = cyc;
    for (int f = 0; f < 4; f++) send_frame(f * 16);
    drain(64);
    chk("t2_stalls", stall_cnt, 0);
    chk("t2_first_latency", obs_cyc[0] - (c0 + 1), 16);
    chk("t2_no_gaps", obs_cyc[63] - obs_cyc[0], 63);
    for (int f = 0; f < 4; f++) check_frame($sformatf("t2f%0d", f), f * 16, f * 16);
    chk("t2_frame_cnt", frame_cnt, 4);

    // ---------------- backpressure ----------------
    do_reset();
    send_frame(0);
    send_frame(16);
    chk("t3_ready_low", bus.in_ready, 0);
    chk("t3_valid_high", bus.out_valid, 1);
    held = bus.out_data;
    chk("t3_head_word", held, wd(0));
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b1;
    bus.in_data  = wd(32);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("t3_no_accept%0d", i), last_acc, 0);
      chk($sformatf("t3_hold%0d", i), bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    w = 0;
    do begin
      cycle();
      w++;
    end while (!last_acc && w < 100);
    chk("t3_ready_after_16_reads", w, 17);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    for (int k = 1; k < 16; k++) send_word(wd(32 + k), 1'b0, w);
    drain(48);
    for (int f = 0; f < 3; f++) check_frame($sformatf("t3f%0d", f), f * 16, f * 16);
    chk("t3_frame_cnt", frame_cnt, 3);

    // ---------------- resync ----------------
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_word(wd(500 + k), k == 0, w);
    chk("t4_sop_err_before", sop_err, 0);
    for (int k = 0; k < 16; k++) send_word(wd(k), k == 0, w);
    chk("t4_sop_err", sop_err, 1);
    drain(16);
    check_frame("t4", 0, 0);
    repeat (4) cycle();
    chk("t4_no_extra", obs_dat.size(), 16);
    chk("t4_idle_valid", bus.out_valid, 0);
    chk("t4_frame_cnt", frame_cnt, 1);

    // ---------------- reset mid-frame and with out_valid ----------------
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) send_word(wd(100 + k), k == 0, w);
    rst_n = 1'b0;
    #1;
    chk("t5a_sop_err", sop_err, 0);
    chk("t5a_frame_cnt", frame_cnt, 0);
    chk("t5a_in_ready", bus.in_ready, 1);
    chk("t5a_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(200);
    chk("t5b_valid_pre", bus.out_valid, 1);
    send_frame(220);
    chk("t5b_ready_pre", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t5b_out_valid", bus.out_valid, 0);
    chk("t5b_out_last", bus.out_last, 0);
    chk("t5b_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_dat.delete();
    obs_last.delete();
    obs_cyc.delete();
    bus.out_ready = 1'b1;
    send_frame(300);
    drain(16);
    check_frame("t5c", 0, 300);
    chk("t5c_frame_cnt", frame_cnt, 1);

    // ---------------- frame counter wrap ----------------
    do_reset();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 255; f++) send_frame(f);
    drain(255 * 16);
    chk("t6_cnt_255", frame_cnt, 255);
    send_frame(7);
    drain(256 * 16);
    chk("t6_cnt_wrap", frame_cnt, 0);
    chk("t6_stalls", stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
